dsp_symbol_upsampler: RTL and testbench
=======================================

# dsp_symbol_upsampler

Consumes 64-QAM baseband symbols from the baseband-to-DSP CDC FIFO in the DSP clock domain. It converts each 4-bit I/Q level code to a scaled signed sample and emits OSR samples per symbol on a valid/ready stream towards the DSP datapath. It prefetches one symbol to keep the stream gapless, and it inserts zero symbols and counts underruns when the FIFO runs dry.

## Interface
- OSR, 4: samples per symbol; legal range 4..16.
- OUT_W, 8: sample width, signed.
- CNT_W, 16: symbol counter width.

- dsp_clk  in  1  DSP clock; all logic on the rising edge.
- rst_dsp  in  1  asynchronous, active-high reset.
- enable  in  1  streaming enable; already synchronised to dsp_clk.
- hold_mode  in  1  1: repeat the symbol in every phase; 0: symbol in phase 0, zeros in the other phases.
- fifo_data_out  in  8  {I[3:0],Q[3:0]}; valid the cycle after fifo_read_enable.
- fifo_empty  in  1  FIFO empty flag.
- fifo_read_enable  out  1  registered one-cycle read strobe.
- sample_i, sample_q  out  OUT_W  signed output samples.
- sample_valid  out  1  output valid.
- sample_ready  in  1  downstream accept.
- symbol_count  out  CNT_W  count of real symbols started; wraps.
- underrun_count  out  8  count of starved symbol periods; saturates at 255.

## Operation
- **Level mapping:**
  - Each nibble is two's complement; the legal levels are odd values -7..+7.
  - Output = nibble sign-extended then shifted left by OUT_W-4. For OUT_W=8: +7 -> 112, -1 -> -16.
  - Code -8 clamps to -7 (-112).
  - Even codes pass unchanged.
- **Prefetch register (next_sym, next_valid):**
  - A read is issued when all of these hold: enable=1, fifo_empty=0, next_valid=0, and no read is outstanding.
  - The data is captured the cycle after the strobe and sets next_valid.
- **Bypass:** if the current symbol's last phase is accepted in the same cycle as a capture, current loads directly from fifo_data_out.
- **States:**
  - IDLE: sample_valid=0. Go to RUN when enable=1 and next_valid=1; load current from next and set phase=0.
  - RUN: present the sample for the current phase. On each accepted transfer (valid&&ready), phase increments. On acceptance of phase OSR-1:
    - if a next symbol is available (or bypass applies), load it and stay in RUN;
    - else if enable=1, go to STARVE;
    - else go to IDLE.
  - STARVE: emit OSR zero samples (valid=1); underrun_count increments once on entry. At the end of the period:
    - if next_valid=1, go to RUN with the new symbol;
    - else if enable=1, start another STARVE period;
    - else go to IDLE.
- **Enable deasserted mid-symbol:**
  - The current symbol (or zero period) completes all OSR phases, then the block goes to IDLE.
  - No new reads are issued.
  - A prefetched symbol is kept and is emitted first after re-enable.
- symbol_count increments when phase 0 of a real symbol is accepted. Zero symbols do not count.
- sample_i/sample_q are held stable while sample_valid=1 and sample_ready=0.

## Timing
- Reset values:
  - state=IDLE, phase=0, next_valid=0, no read outstanding.
  - fifo_read_enable=0, sample_valid=0, sample_i=sample_q=0.
  - symbol_count=0, underrun_count=0.
- Cold-start latency from IDLE with enable=1:
  - fifo_empty falls and is seen in cycle 0.
  - fifo_read_enable=1 in cycle 1.
  - Capture in cycle 2; next_valid=1 in cycle 3.
  - sample_valid=1 in cycle 4.
- Throughput: with sample_ready held at 1 and the FIFO non-empty, the output is gapless at OSR>=4.
- Asynchronous reset asserted mid-operation:
  - All outputs go to their reset values immediately.
  - Any in-flight FIFO read data is discarded.

## Structure
- Shared package qam_dsp_pkg:
  - state enum (IDLE, RUN, STARVE);
  - constants IQ_W=4, LEVEL_MIN=-7, LEVEL_MAX=7.
- One combinational sub-module, qam_level_scaler: nibble to OUT_W with clamp, instantiated once each for I and Q.

## Test plan
- OSR=4, hold_mode=1, ready=1. Write 0x79 (I=+7, Q=-7) -> four samples (112,-112); symbol_count=1; first valid 4 cycles after empty falls.
- hold_mode=0. Write 0x31 -> samples (48,16),(0,0),(0,0),(0,0).
- Write 0x88 -> samples (-112,-112) (clamp).
- Write 2 symbols then leave the FIFO empty, enable=1 -> 8 real samples, then zero samples; underrun_count=1 per 4 zeros. Refill -> resume at a symbol boundary.
- Hold sample_ready=0 for 5 cycles mid-symbol -> outputs frozen, no phase advance, no extra FIFO read beyond the prefetch.
- Assert rst_dsp at phase 2 -> sample_valid=0 and both counters 0 immediately. After release with enable=1 and the FIFO non-empty -> normal cold start.

Source files
------------

// File: rtl/qam_dsp_pkg.sv
// Shared types and constants for the 64-QAM DSP-side symbol path.
// Ports: none (package only).
// Holds the upsampler state encoding and the legal I/Q level range.
package qam_dsp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STARVE = 2'd2
    } state_t;

    localparam int IQ_W      = 4;
    localparam int LEVEL_MIN = -7;
    localparam int LEVEL_MAX = 7;

endpackage

// File: rtl/qam_level_scaler.sv
// Maps one two's complement I/Q level nibble to a scaled signed sample.
// Ports: code (nibble in), level (OUT_W signed out). Purely combinational.
// The unused code -8 clamps to -7; other codes scale by 2^(OUT_W-IQ_W).
module qam_level_scaler
    import qam_dsp_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic [IQ_W-1:0]         code,
    output logic signed [OUT_W-1:0] level
);

    localparam int SH = OUT_W - IQ_W;
    localparam logic signed [IQ_W-1:0] MIN_CODE = IQ_W'(LEVEL_MIN);

    logic signed [IQ_W-1:0] lvl;

    always_comb begin
        lvl = $signed(code);
        if (lvl < MIN_CODE) begin
            lvl = MIN_CODE;
        end
    end

    // Appending zeros is the sign-extend-then-shift-left of the level.
    assign level = {lvl, {SH{1'b0}}};

endmodule

// File: rtl/dsp_symbol_upsampler.sv
// Upsamples 64-QAM symbols from the CDC FIFO into OSR samples per symbol.
// Ports: dsp_clk/rst_dsp, enable, hold_mode, FIFO read side (fifo_data_out,
// fifo_empty, fifo_read_enable), sample stream (sample_i/q, sample_valid,
// sample_ready), symbol_count and underrun_count status.
module dsp_symbol_upsampler
    import qam_dsp_pkg::*;
#(
    parameter int OSR   = 4,
    parameter int OUT_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                    dsp_clk,
    input  logic                    rst_dsp,
    input  logic                    enable,
    input  logic                    hold_mode,
    input  logic [7:0]              fifo_data_out,
    input  logic                    fifo_empty,
    output logic                    fifo_read_enable,
    output logic signed [OUT_W-1:0] sample_i,
    output logic signed [OUT_W-1:0] sample_q,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic [CNT_W-1:0]        symbol_count,
    output logic [7:0]              underrun_count
);

    localparam int PH_W = $clog2(OSR);
    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(OSR - 1);

    state_t          state, state_nxt;
    logic [PH_W-1:0] phase, phase_nxt;
    logic [7:0]      cur_sym;
    logic [7:0]      next_sym;
    logic            next_valid;
    logic            read_capture;   // FIFO data is on fifo_data_out this cycle
    logic            load_cur;
    logic            starve_entry;
    logic            fire;
    logic            avail;
    logic            read_issue;
    logic            show_sym;
    logic signed [OUT_W-1:0] scaled_i, scaled_q;

    qam_level_scaler #(.OUT_W(OUT_W)) u_scale_i (.code(cur_sym[7:4]), .level(scaled_i));
    qam_level_scaler #(.OUT_W(OUT_W)) u_scale_q (.code(cur_sym[3:0]), .level(scaled_q));

    assign sample_valid = (state != IDLE);
    assign fire         = sample_valid && sample_ready;
    // A symbol landing from the FIFO this cycle counts as available (bypass).
    assign avail        = next_valid || read_capture;
    // At most one read in flight, and only into an empty prefetch slot.
    assign read_issue   = enable && !fifo_empty && !next_valid
                          && !fifo_read_enable && !read_capture;
    assign show_sym     = (state == RUN) && (hold_mode || (phase == '0));
    assign sample_i     = show_sym ? scaled_i : '0;
    assign sample_q     = show_sym ? scaled_q : '0;

    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase;
        load_cur     = 1'b0;
        starve_entry = 1'b0;
        case (state)
            IDLE: begin
                if (enable && next_valid) begin
                    state_nxt = RUN;
                    phase_nxt = '0;
                    load_cur  = 1'b1;
                end
            end
            RUN, STARVE: begin
                if (fire) begin
                    if (phase == LAST_PHASE) begin
                        phase_nxt = '0;
                        // With enable low the period ends in IDLE and any
                        // prefetched symbol waits for re-enable.
                        if (enable && avail) begin
                            state_nxt = RUN;
                            load_cur  = 1'b1;
                        end else if (enable) begin
                            state_nxt    = STARVE;
                            starve_entry = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        phase_nxt = phase + PH_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                phase_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge dsp_clk or posedge rst_dsp) begin
        if (rst_dsp) begin
            state            <= IDLE;
            phase            <= '0;
            cur_sym          <= '0;
            next_sym         <= '0;
            next_valid       <= 1'b0;
            read_capture     <= 1'b0;
            fifo_read_enable <= 1'b0;
            symbol_count     <= '0;
            underrun_count   <= '0;
        end else begin
            state            <= state_nxt;
            phase            <= phase_nxt;
            fifo_read_enable <= read_issue;
            read_capture     <= fifo_read_enable;

            if (load_cur) begin
                cur_sym    <= next_valid ? next_sym : fifo_data_out;
                next_valid <= 1'b0;
            end else if (read_capture) begin
                next_sym   <= fifo_data_out;
                next_valid <= 1'b1;
            end

            if ((state == RUN) && fire && (phase == '0)) begin
                symbol_count <= symbol_count + CNT_W'(1);
            end

            if (starve_entry && (underrun_count != 8'hFF)) begin
                underrun_count <= underrun_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_dsp_symbol_upsampler.sv
module tb_dsp_symbol_upsampler;

    localparam int OSR   = 4;
    localparam int OUT_W = 8;
    localparam int CNT_W = 16;

    logic                    dsp_clk = 1'b0;
    logic                    rst_dsp = 1'b1;
    logic                    enable = 1'b0;
    logic                    hold_mode = 1'b1;
    logic [7:0]              fifo_data_out = 8'h00;
    logic                    fifo_empty = 1'b1;
    logic                    fifo_read_enable;
    logic signed [OUT_W-1:0] sample_i, sample_q;
    logic                    sample_valid;
    logic                    sample_ready = 1'b0;
    logic [CNT_W-1:0]        symbol_count;
    logic [7:0]              underrun_count;

    dsp_symbol_upsampler #(.OSR(OSR), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .dsp_clk          (dsp_clk),
        .rst_dsp          (rst_dsp),
        .enable           (enable),
        .hold_mode        (hold_mode),
        .fifo_data_out    (fifo_data_out),
        .fifo_empty       (fifo_empty),
        .fifo_read_enable (fifo_read_enable),
        .sample_i         (sample_i),
        .sample_q         (sample_q),
        .sample_valid     (sample_valid),
        .sample_ready     (sample_ready),
        .symbol_count     (symbol_count),
        .underrun_count   (underrun_count)
    );

    always #5 dsp_clk = ~dsp_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference level mapping: odd levels scale by 2^(OUT_W-4), -8 clamps to -7.
    function automatic int scale(input logic [3:0] n);
        int v;
        v = int'(n);
        if (v > 7) v = v - 16;
        if (v < -7) v = -7;
        return v * (1 << (OUT_W - 4));
    endfunction

    // Behavioural FIFO: data appears the cycle after a read strobe.
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int         reads = 0;
    logic       re;

    always begin
        @(posedge dsp_clk);
        re = fifo_read_enable;
        #1;
        if (re && fifo_q.size() > 0) begin
            fifo_data_out = fifo_q.pop_front();
            reads++;
        end
        #1;
        fifo_empty = (fifo_q.size() == 0);
    end

    // Output model: the stream is a sequence of OSR-sample periods, each either
    // the next pushed symbol or an all-zero underrun period.
    int         k = 0;
    int         real_cnt = 0;
    int         zero_cnt = 0;
    logic       cur_real = 1'b0;
    logic [7:0] cur_sym = 8'h00;
    logic       prev_stall = 1'b0;
    int         prev_i, prev_q;
    int         si, sq, ei, eq;

    always @(negedge dsp_clk) begin
        if (rst_dsp) begin
            k          = 0;
            real_cnt   = 0;
            zero_cnt   = 0;
            cur_real   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            si = int'(sample_i);
            sq = int'(sample_q);
            if (prev_stall) begin
                check("stall_valid", int'(sample_valid), 1);
                check("stall_i", si, prev_i);
                check("stall_q", sq, prev_q);
            end
            if (sample_valid && sample_ready) begin
                if (k == 0) begin
                    check("symbol_count", int'(symbol_count), real_cnt % (1 << CNT_W));
                    if (si != 0 || sq != 0) begin
                        check("symbol_expected", int'(exp_q.size() > 0), 1);
                        if (exp_q.size() > 0) begin
                            cur_sym  = exp_q.pop_front();
                            cur_real = 1'b1;
                            real_cnt++;
                        end else begin
                            cur_real = 1'b0;
                        end
                    end else begin
                        cur_real = 1'b0;
                        zero_cnt++;
                    end
                end
                if (cur_real && (hold_mode || k == 0)) begin
                    ei = scale(cur_sym[7:4]);
                    eq = scale(cur_sym[3:0]);
                end else begin
                    ei = 0;
                    eq = 0;
                end
                check("sample_i", si, ei);
                check("sample_q", sq, eq);
                k = (k + 1) % OSR;
            end
            prev_stall = sample_valid && !sample_ready;
            prev_i     = si;
            prev_q     = sq;
        end
    end

    task automatic push(input logic [7:0] s);
        fifo_q.push_back(s);
        exp_q.push_back(s);
    endtask

    task automatic cold_start(input logic [7:0] s);
        int lat;
        @(posedge dsp_clk);
        #1;
        push(s);
        lat = 0;
        do begin
            @(posedge dsp_clk);
            lat++;
            @(negedge dsp_clk);
        end while (!sample_valid && lat < 20);
        check("cold_latency", lat, 4);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge dsp_clk);
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        #1;
    endtask

    task automatic wait_phase(input int target);
        int n;
        n = 0;
        do begin
            @(posedge dsp_clk);
            #3;
            n++;
        end while (!(sample_valid && k == target) && n < 100);
        check("wait_phase", int'(sample_valid && k == target), 1);
    endtask

    task automatic settle();
        enable       = 1'b0;
        sample_ready = 1'b1;
        repeat (3 * OSR + 4) @(posedge dsp_clk);
        #1;
        check("idle_valid", int'(sample_valid), 0);
        check("underrun_count", int'(underrun_count), (zero_cnt > 255) ? 255 : zero_cnt);
        check("symbol_total", int'(symbol_count), real_cnt % (1 << CNT_W));
    endtask

    int z0, r0;

    initial begin
        // Reset values
        repeat (3) @(posedge dsp_clk);
        #1;
        check("rst_valid", int'(sample_valid), 0);
        check("rst_read", int'(fifo_read_enable), 0);
        check("rst_i", int'(sample_i), 0);
        check("rst_q", int'(sample_q), 0);
        check("rst_symcnt", int'(symbol_count), 0);
        check("rst_undcnt", int'(underrun_count), 0);
        @(negedge dsp_clk);
        rst_dsp = 1'b0;

        // Hold mode, full-scale symbol, cold-start latency
        enable       = 1'b1;
        sample_ready = 1'b1;
        hold_mode    = 1'b1;
        cold_start(8'h79);
        wait_drain(50);
        settle();
        check("t1_symcnt", int'(symbol_count), 1);

        // Impulse mode and the -8 clamp
        hold_mode = 1'b0;
        enable    = 1'b1;
        push(8'h31);
        push(8'h88);
        wait_drain(60);
        settle();

        // Starvation then refill
        hold_mode = 1'b1;
        enable    = 1'b1;
        z0 = zero_cnt;
        push(8'($urandom_range(1, 255)));
        push(8'($urandom_range(1, 255)));
        wait_drain(60);
        repeat (14) @(posedge dsp_clk);
        #1;
        push(8'($urandom_range(1, 255)));
        push(8'($urandom_range(1, 255)));
        wait_drain(60);
        settle();
        check("t4_starved", int'((zero_cnt - z0) >= 2), 1);

        // Gapless stream with a 5-cycle mid-symbol stall
        enable = 1'b1;
        z0 = zero_cnt;
        for (int i = 0; i < 6; i++) push(8'($urandom_range(1, 255)));
        wait_phase(1);
        wait_phase(1);
        sample_ready = 1'b0;
        r0 = reads;
        repeat (5) @(posedge dsp_clk);
        #3;
        check("stall_reads", int'((reads - r0) <= 1), 1);
        check("stall_phase", k, 1);
        sample_ready = 1'b1;
        wait_drain(100);
        check("gapless", zero_cnt - z0, 0);
        settle();

        // Randomised traffic, backpressure and enable toggling
        for (int b = 0; b < 6; b++) begin
            hold_mode = 1'($urandom);
            enable    = 1'b1;
            for (int c = 0; c < 40; c++) begin
                @(posedge dsp_clk);
                #1;
                sample_ready = ($urandom % 4) != 0;
                enable       = ($urandom % 8) != 0;
                if ($urandom % 3 == 0) push(8'($urandom_range(1, 255)));
            end
            enable       = 1'b1;
            sample_ready = 1'b1;
            wait_drain(300);
            settle();
        end

        // Asynchronous reset at phase 2, then a normal cold start
        hold_mode    = 1'b1;
        enable       = 1'b1;
        sample_ready = 1'b1;
        for (int i = 0; i < 3; i++) push(8'($urandom_range(1, 255)));
        wait_phase(2);
        rst_dsp = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        #1;
        check("arst_valid", int'(sample_valid), 0);
        check("arst_symcnt", int'(symbol_count), 0);
        check("arst_undcnt", int'(underrun_count), 0);
        check("arst_read", int'(fifo_read_enable), 0);
        check("arst_i", int'(sample_i), 0);
        repeat (2) @(negedge dsp_clk);
        rst_dsp = 1'b0;
        cold_start(8'($urandom_range(1, 255)));
        wait_drain(50);
        settle();
        check("post_rst_symcnt", int'(symbol_count), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
